// File: rtl/fix_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fix_pkg : header-word layout and packer state shared with the unpacker.  rev 1.0
// ---------------------------------------------------------------------------
package fix_pkg;

  localparam int FIX_HDR_ID_LSB  = 0;
  localparam int FIX_HDR_ID_W    = 2;
  localparam int FIX_HDR_LEN_LSB = 4;
  localparam int FIX_HDR_LEN_W   = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_DISCARD = 3'd2,
    ST_HEADER  = 3'd3,
    ST_DRAIN   = 3'd4
  } fix_state_e;

  function automatic logic [63:0] fix_hdr_word(input logic [FIX_HDR_ID_W-1:0]  id,
                                               input logic [FIX_HDR_LEN_W-1:0] len);
    logic [63:0] w;
    w = '0;
    w[FIX_HDR_ID_LSB +: FIX_HDR_ID_W]   = id;
    w[FIX_HDR_LEN_LSB +: FIX_HDR_LEN_W] = len;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fix_word_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fix_word_buf : DEPTH x 64 register array, one write port, async read.  rev 1.0
// ---------------------------------------------------------------------------
module fix_word_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/fix_msg_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fix_msg_packer : buffers one framed FIX message, emits header + LE-packed words.  rev 1.0
// ---------------------------------------------------------------------------
module fix_msg_packer
  import fix_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int PTR_W     = $clog2(MAX_WORDS) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_data_i,
  input  logic        in_sop_i,
  input  logic        in_eop_i,
  input  logic [1:0]  in_id_i,
  input  logic        full_i,
  output logic        wrreq_o,
  output logic [63:0] wdata_o,
  output logic        drop_o
);

  localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  fix_state_e       state_q, state_d;
  logic [2:0]       lane_q, lane_d;
  logic [PTR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [PTR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]       id_q, id_d;
  logic [63:0]      word_q, word_d;
  logic             drop_q, drop_d;

  logic             buf_we;
  logic [AW-1:0]    buf_waddr;
  logic [63:0]      buf_wdata;
  logic [63:0]      buf_rdata;

  logic             accept;
  logic             start;
  logic [63:0]      lane_word;
  logic [63:0]      first_word;

  fix_word_buf #(
    .DEPTH (MAX_WORDS),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (buf_wdata),
    .raddr_i (rd_cnt_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  assign accept     = in_valid_i && in_ready_o;
  assign start      = accept && in_sop_i;
  assign first_word = 64'(in_data_i);
  assign lane_word  = word_q | (64'(in_data_i) << {lane_q, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q   <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      id_q     <= '0;
      word_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      id_q     <= id_d;
      word_q   <= word_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    id_d      = id_q;
    word_d    = word_q;
    drop_d    = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = wr_cnt_q[AW-1:0];
    buf_wdata = lane_word;

    // A sop byte always (re)starts collection; only COLLECT has a message to drop.
    if (start) begin
      drop_d    = (state_q == ST_COLLECT);
      id_d      = in_id_i;
      buf_waddr = '0;
      buf_wdata = first_word;
      if (in_eop_i) begin
        buf_we   = 1'b1;
        wr_cnt_d = PTR_W'(1);
        word_d   = '0;
        lane_d   = '0;
        state_d  = ST_HEADER;
      end else begin
        wr_cnt_d = '0;
        word_d   = first_word;
        lane_d   = 3'd1;
        state_d  = ST_COLLECT;
      end
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            if (wr_cnt_q == PTR_W'(MAX_WORDS)) begin
              drop_d  = in_eop_i;
              state_d = in_eop_i ? ST_IDLE : ST_DISCARD;
            end else if (lane_q == 3'd7 || in_eop_i) begin
              buf_we   = 1'b1;
              wr_cnt_d = wr_cnt_q + PTR_W'(1);
              word_d   = '0;
              lane_d   = '0;
              if (in_eop_i) begin
                state_d = ST_HEADER;
              end
            end else begin
              word_d = lane_word;
              lane_d = lane_q + 3'd1;
            end
          end
        end
        ST_DISCARD: begin
          if (accept && in_eop_i) begin
            drop_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_HEADER: begin
          if (!full_i) begin
            rd_cnt_d = '0;
            state_d  = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!full_i) begin
            rd_cnt_d = rd_cnt_q + PTR_W'(1);
            if (rd_cnt_q == wr_cnt_q - PTR_W'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated by rst so nothing is written or accepted during the reset cycle.
  always_comb begin
    in_ready_o = !rst && (state_q == ST_IDLE || state_q == ST_COLLECT ||
                          state_q == ST_DISCARD);
    wrreq_o    = !rst && !full_i && (state_q == ST_HEADER || state_q == ST_DRAIN);
    drop_o     = !rst && drop_q;
    wdata_o    = '0;
    if (wrreq_o) begin
      wdata_o = (state_q == ST_HEADER) ? fix_hdr_word(id_q, FIX_HDR_LEN_W'(wr_cnt_q))
                                       : buf_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fix_msg_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fix_msg_packer : directed vectors, scoreboard queue of expected FIFO words.  rev 1.0
// ---------------------------------------------------------------------------
module tb_fix_msg_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_data_i;
  logic        in_sop_i;
  logic        in_eop_i;
  logic [1:0]  in_id_i;
  logic        full_i;
  logic        wrreq_o;
  logic [63:0] wdata_o;
  logic        drop_o;

  fix_msg_packer #(.MAX_WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_sop_i   (in_sop_i),
    .in_eop_i   (in_eop_i),
    .in_id_i    (in_id_i),
    .full_i     (full_i),
    .wrreq_o    (wrreq_o),
    .wdata_o    (wdata_o),
    .drop_o     (drop_o)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q [$];
  logic [7:0]  tx [0:63];
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          n_wr    = 0;
  int          n_drop  = 0;

  always @(negedge clk) begin
    if (wrreq_o) begin
      n_wr++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got %h, required no write", wdata_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (wdata_o !== e) begin
          n_bad++;
          $display("FAIL fifo_word: got %h, required %h", wdata_o, e);
        end
      end
    end
    if (drop_o) n_drop++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic fill_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) tx[i] = first + 8'(i);
  endtask

  task automatic send_msg(input logic [1:0] id, input int n, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      int g;
      in_valid_i = 1'b1;
      in_data_i  = tx[i];
      in_sop_i   = (i == 0);
      in_eop_i   = with_eop && (i == n - 1);
      in_id_i    = id;
      g = 0;
      while (!in_ready_o && g < 200) begin
        @(posedge clk); #1;
        g++;
      end
      if (g >= 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ready_timeout: got in_ready_o=0, required 1");
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    in_sop_i   = 1'b0;
    in_eop_i   = 1'b0;
  endtask

  task automatic wait_ready(output int low_cycles);
    int g;
    g = 0;
    while (!in_ready_o && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    low_cycles = g;
    if (g >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got in_ready_o=0, required 1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    int wr0;
    rst        = 1'b1;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_sop_i   = 1'b0;
    in_eop_i   = 1'b0;
    in_id_i    = '0;
    full_i     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready_o), 64'd0);
    check("rst_wrreq", 64'(wrreq_o), 64'd0);
    check("rst_wdata", wdata_o, 64'd0);
    check("rst_drop", 64'(drop_o), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", 64'(in_ready_o), 64'd1);

    // short message, id 2
    tx[0] = 8'h38; tx[1] = 8'h3D; tx[2] = 8'h46; tx[3] = 8'h49; tx[4] = 8'h58;
    exp_q.push_back(64'h0000_0000_0000_0012);
    exp_q.push_back(64'h0000_0058_4946_3D38);
    send_msg(2'd2, 5, 1'b1);
    wait_ready(lows);
    check("short_ready_low", 64'(lows), 64'd2);

    // exactly one word
    fill_seq(8'h01, 8);
    exp_q.push_back(64'h0000_0000_0000_0011);
    exp_q.push_back(64'h0807_0605_0403_0201);
    send_msg(2'd1, 8, 1'b1);
    wait_ready(lows);

    // one byte into the second word
    fill_seq(8'h01, 9);
    exp_q.push_back(64'h0000_0000_0000_0023);
    exp_q.push_back(64'h0807_0605_0403_0201);
    exp_q.push_back(64'h0000_0000_0000_0009);
    send_msg(2'd3, 9, 1'b1);
    wait_ready(lows);

    // backpressure during drain of a 3-word message
    fill_seq(8'h01, 24);
    exp_q.push_back(64'h0000_0000_0000_0030);
    exp_q.push_back(64'h0807_0605_0403_0201);
    exp_q.push_back(64'h100F_0E0D_0C0B_0A09);
    exp_q.push_back(64'h1817_1615_1413_1211);
    wr0 = n_wr;
    send_msg(2'd0, 24, 1'b1);
    @(posedge clk); #1;
    full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_wrreq", 64'(wrreq_o), 64'd0);
      @(posedge clk); #1;
    end
    full_i = 1'b0;
    wait_ready(lows);
    check("bp_write_count", 64'(n_wr - wr0), 64'd4);

    // overflow of a 4-word buffer, then a 1-byte message
    fill_seq(8'h00, 33);
    wr0 = n_wr;
    send_msg(2'd0, 33, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_no_writes", 64'(n_wr - wr0), 64'd0);
    check("ovf_drop_count", 64'(n_drop), 64'd1);
    tx[0] = 8'h41;
    exp_q.push_back(64'h0000_0000_0000_0011);
    exp_q.push_back(64'h0000_0000_0000_0041);
    send_msg(2'd1, 1, 1'b1);
    wait_ready(lows);

    // restart: unterminated message superseded by a new sop
    fill_seq(8'hAA, 3);
    send_msg(2'd2, 3, 1'b0);
    fill_seq(8'h55, 2);
    exp_q.push_back(64'h0000_0000_0000_0013);
    exp_q.push_back(64'h0000_0000_0000_5655);
    send_msg(2'd3, 2, 1'b1);
    wait_ready(lows);
    check("restart_drop_count", 64'(n_drop), 64'd2);

    // reset in the middle of a drain
    fill_seq(8'h01, 24);
    exp_q.push_back(64'h0000_0000_0000_0032);
    send_msg(2'd2, 24, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_wrreq", 64'(wrreq_o), 64'd0);
    check("mid_rst_wdata", wdata_o, 64'd0);
    check("mid_rst_drop", 64'(drop_o), 64'd0);
    wr0 = n_wr;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_writes", 64'(n_wr - wr0), 64'd0);
    tx[0] = 8'h77;
    exp_q.push_back(64'h0000_0000_0000_0010);
    exp_q.push_back(64'h0000_0000_0000_0077);
    send_msg(2'd0, 1, 1'b1);
    wait_ready(lows);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("final_drop_count", 64'(n_drop), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
